// File: rtl/pea_pkg.sv
// Shared PEA types: execution FSM state, loop controller state and a sizing helper.
package pea_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LC_IDLE  = 2'd0,
    LC_RUN   = 2'd1,
    LC_DRAIN = 2'd2,
    LC_WAIT  = 2'd3
  } lc_state_t;

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/loop_ctrl_wrap_counter.sv
// Modulo-len up-counter with a terminal flag; one instance per loop level.
module wrap_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  // len==0 never reaches this counter while enabled, so the wrapped len-1 is harmless.
  assign at_max = (cnt == (len - CNT_W'(1)));

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_max ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/loop_ctrl.sv
// Two-level iteration sequencer driven by the PEA execution FSM; drains the
// pipeline after the final iteration and returns a one-cycle end pulse.
module loop_ctrl
  import pea_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  state_t           state_i,
  input  logic [CNT_W-1:0] cfg_inner_len_i,
  input  logic [CNT_W-1:0] cfg_outer_len_i,
  input  logic             stall_i,
  output logic             iter_valid_o,
  output logic [CNT_W-1:0] inner_idx_o,
  output logic [CNT_W-1:0] outer_idx_o,
  output logic             last_o,
  output logic             end_o,
  output logic             busy_o
);

  localparam int                 DRAIN_W    = cnt_bits(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

  lc_state_t          lc_q, lc_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   inner_len_q, outer_len_q;
  logic               is_exec, start, zero_len;
  logic               issue, final_iter, cnt_clr;
  logic               inner_at_max, outer_at_max;

  assign is_exec  = (state_i == EXEC);
  assign start    = (lc_q == LC_IDLE) && is_exec;
  assign zero_len = (cfg_inner_len_i == '0) || (cfg_outer_len_i == '0);

  assign issue      = (lc_q == LC_RUN) && !stall_i;
  assign final_iter = issue && inner_at_max && outer_at_max;

  // Indices are cleared on the same edge that leaves LC_RUN (wrap, abort or reset).
  assign cnt_clr = (lc_d != LC_RUN);

  wrap_counter #(.CNT_W(CNT_W)) u_inner (
    .clk    (clk_i),
    .rst    (rst_i),
    .en     (issue),
    .clr    (cnt_clr),
    .len    (inner_len_q),
    .cnt    (inner_idx_o),
    .at_max (inner_at_max)
  );

  wrap_counter #(.CNT_W(CNT_W)) u_outer (
    .clk    (clk_i),
    .rst    (rst_i),
    .en     (issue && inner_at_max),
    .clr    (cnt_clr),
    .len    (outer_len_q),
    .cnt    (outer_idx_o),
    .at_max (outer_at_max)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lc_q        <= LC_IDLE;
      drain_q     <= '0;
      inner_len_q <= '0;
      outer_len_q <= '0;
    end else begin
      lc_q    <= lc_d;
      drain_q <= drain_d;
      if (start) begin
        inner_len_q <= cfg_inner_len_i;
        outer_len_q <= cfg_outer_len_i;
      end
    end
  end

  // NOTE: every variable is given a default before the case so no path
  // through this block leaves it unassigned, which would infer a latch.
  always_comb begin
    lc_d    = lc_q;
    drain_d = drain_q;
    case (lc_q)
      LC_IDLE: begin
        if (is_exec) begin
          if (zero_len) begin
            lc_d    = LC_DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            lc_d = LC_RUN;
          end
        end
      end
      LC_RUN: begin
        if (!is_exec) begin
          lc_d = LC_IDLE;
        end else if (final_iter) begin
          lc_d    = LC_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      LC_DRAIN: begin
        if (!is_exec) begin
          lc_d    = LC_IDLE;
          drain_d = '0;
        end else if (drain_q == '0) begin
          lc_d = LC_WAIT;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      LC_WAIT: begin
        if (!is_exec) lc_d = LC_IDLE;
      end
      default: begin
        lc_d    = LC_IDLE;
        drain_d = '0;
      end
    endcase
  end

  // All outputs decode registered state plus stall_i only; state_i never reaches them.
  assign iter_valid_o = issue;
  assign last_o       = final_iter;
  assign end_o        = (lc_q == LC_DRAIN) && (drain_q == '0);
  assign busy_o       = (lc_q != LC_IDLE);

  end_is_single_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    end_o |=> !end_o);
  last_implies_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    last_o |-> iter_valid_o);

endmodule
